// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared types for the SRAM-backed FIFO controller: output buffer state
// encodings and a helper that turns a buffer state into an occupancy.
package sram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    OB_EMPTY = 2'd0,
    OB_ONE   = 2'd1,
    OB_TWO   = 2'd2
  } outbuf_state_e;

  function automatic logic [1:0] outbuf_fill(input outbuf_state_e s);
    case (s)
      OB_ONE:  return 2'd1;
      OB_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Bundle of the push/pop handshakes, the occupancy count and the dual-port
// SRAM bus. The master side is the FIFO controller; the slave side is the
// producer, consumer and SRAM around it.
interface sram_fifo_ctrl_if #(
  parameter int ADDRW = 8,
  parameter int DATAW = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic [ADDRW+1:0] count;
  logic             sram_wr_en;
  logic [ADDRW-1:0] sram_wr_addr;
  logic [DATAW-1:0] sram_wr_data;
  logic             sram_rd_en;
  logic [ADDRW-1:0] sram_rd_addr;
  logic [DATAW-1:0] sram_rd_data;

  modport master (
    input  in_valid, in_data, out_ready, sram_rd_data,
    output in_ready, out_valid, out_data, count,
           sram_wr_en, sram_wr_addr, sram_wr_data,
           sram_rd_en, sram_rd_addr
  );

  modport slave (
    output in_valid, in_data, out_ready, sram_rd_data,
    input  in_ready, out_valid, out_data, count,
           sram_wr_en, sram_wr_addr, sram_wr_data,
           sram_rd_en, sram_rd_addr
  );

endinterface

// File: rtl/sram_fifo_ctrl_outbuf.sv
// Two-entry head/skid buffer that sits after the SRAM read port. The head
// register feeds out_data; the skid register catches a read that lands while
// the head is still waiting to be popped.
module fifo_outbuf
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap,
  input  logic [DATAW-1:0] cap_data,
  input  logic             pop,
  output logic             valid,
  output logic [DATAW-1:0] head,
  output logic [1:0]       buf_cnt
);

  outbuf_state_e    state_q, state_d;
  logic [DATAW-1:0] head_q, head_d;
  logic [DATAW-1:0] skid_q, skid_d;

  // Next state and data moves: capture fills head first, then skid; a pop
  // promotes the skid (or a same-cycle capture) into the head.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      OB_EMPTY: begin
        if (cap) begin
          state_d = OB_ONE;
          head_d  = cap_data;
        end
      end
      OB_ONE: begin
        if (pop && cap) begin
          head_d = cap_data;
        end else if (pop) begin
          state_d = OB_EMPTY;
        end else if (cap) begin
          state_d = OB_TWO;
          skid_d  = cap_data;
        end
      end
      OB_TWO: begin
        if (pop) begin
          state_d = OB_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = OB_EMPTY;
    endcase
  end

  // State register; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers carry no reset since state marks them invalid.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  assign valid   = (state_q != OB_EMPTY);
  assign head    = head_q;
  assign buf_cnt = outbuf_fill(state_q);

  // The read-issue rule in the controller never lets a read land on a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n) !(cap && (state_q == OB_TWO)));

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around an external dual-port SRAM. Pushes become SRAM
// writes at wptr; reads are issued early enough that a two-entry output
// buffer hides the one-cycle read latency and the pop side drains one
// entry per cycle.
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int ADDRW = 8,
  parameter int DATAW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_fifo_ctrl_if.master  bus
);

  localparam logic [ADDRW:0] FULL_CNT = {1'b1, {ADDRW{1'b0}}};

  logic [ADDRW-1:0] wptr_q, wptr_d;
  logic [ADDRW-1:0] rptr_q, rptr_d;
  logic [ADDRW:0]   sram_cnt_q, sram_cnt_d;
  logic             inflight_q, inflight_d;

  logic             in_ready;
  logic             push;
  logic             pop;
  logic             rd_issue;
  logic [2:0]       occ_after;
  logic             out_valid;
  logic [DATAW-1:0] out_data;
  logic [1:0]       buf_cnt;

  // Handshakes, read issue and pointer/count updates. A read is only issued
  // when the landing data is guaranteed a buffer slot, counting a pop this
  // cycle as freeing one. sram_cnt is the registered value, so an entry
  // written this cycle is not yet eligible for reading.
  always_comb begin
    in_ready   = rst_n & (sram_cnt_q != FULL_CNT);
    push       = bus.in_valid & in_ready;
    pop        = out_valid & bus.out_ready;
    occ_after  = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    rd_issue   = rst_n & (sram_cnt_q != '0) & (occ_after < 3'd2);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    sram_cnt_d = sram_cnt_q;
    inflight_d = rd_issue;
    if (push) begin
      wptr_d = wptr_q + ADDRW'(1);
    end
    if (rd_issue) begin
      rptr_d = rptr_q + ADDRW'(1);
    end
    case ({push, rd_issue})
      2'b10:   sram_cnt_d = sram_cnt_q + (ADDRW+1)'(1);
      2'b01:   sram_cnt_d = sram_cnt_q - (ADDRW+1)'(1);
      default: sram_cnt_d = sram_cnt_q;
    endcase
  end

  // Pointer, SRAM occupancy and in-flight registers; reset drops everything
  // including a read whose data is still on its way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_outbuf #(
    .DATAW (DATAW)
  ) u_outbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (inflight_q),
    .cap_data (bus.sram_rd_data),
    .pop      (pop),
    .valid    (out_valid),
    .head     (out_data),
    .buf_cnt  (buf_cnt)
  );

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data;
  assign bus.count        = {1'b0, sram_cnt_q}
                          + {{(ADDRW+1){1'b0}}, inflight_q}
                          + {{ADDRW{1'b0}}, buf_cnt};
  assign bus.sram_wr_en   = push;
  assign bus.sram_wr_addr = wptr_q;
  assign bus.sram_wr_data = bus.in_data;
  assign bus.sram_rd_en   = rd_issue;
  assign bus.sram_rd_addr = rptr_q;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a 4-entry behavioural dual-port SRAM. A
// queue-based model predicts every output each cycle; directed scenarios
// add hand-computed expectations on latency, fill level and ordering.
module tb_sram_fifo_ctrl;

  localparam int ADDRW = 2;
  localparam int DATAW = 8;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sram_fifo_ctrl_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  sram_fifo_ctrl #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: controls registered on posedge, array read-before-write on negedge.
  logic [DATAW-1:0] mem [DEPTH];
  logic             sram_we_r, sram_re_r;
  logic [ADDRW-1:0] sram_wa_r, sram_ra_r;
  logic [DATAW-1:0] sram_wd_r, sram_rd_q;

  always @(posedge clk) begin
    sram_we_r <= bus.sram_wr_en;
    sram_wa_r <= bus.sram_wr_addr;
    sram_wd_r <= bus.sram_wr_data;
    sram_re_r <= bus.sram_rd_en;
    sram_ra_r <= bus.sram_rd_addr;
  end

  always @(negedge clk) begin
    if (sram_re_r === 1'b1) sram_rd_q <= mem[sram_ra_r];
    if (sram_we_r === 1'b1) mem[sram_wa_r] <= sram_wd_r;
  end

  assign bus.sram_rd_data = sram_rd_q;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // One cycle of stimulus: drive just after the edge, return mid-cycle for sampling.
  task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] d, input logic r);
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #3;
  endtask

  // Model state: entries sitting in the SRAM, one read in flight, buffered head
  // entries, plus the plain accepted-order scoreboard.
  logic [7:0]       m_sram[$];
  logic [7:0]       m_fly[$];
  logic [7:0]       m_out[$];
  logic [7:0]       sb[$];
  logic [ADDRW-1:0] m_wptr = '0;
  logic [ADDRW-1:0] m_rptr = '0;
  bit               model_on = 1'b0;
  bit               e_ready, e_ov, e_pop, e_push, e_rd;
  int               e_count;
  logic [7:0]       sb_head;

  // Compare every output against the model, then advance the model one clock.
  always @(negedge clk) begin
    if (model_on) begin
      e_ready = (rst_n === 1'b1) && (m_sram.size() != DEPTH);
      e_ov    = (m_out.size() != 0);
      e_count = m_sram.size() + m_fly.size() + m_out.size();
      e_pop   = e_ov && (bus.out_ready === 1'b1);
      e_push  = (bus.in_valid === 1'b1) && e_ready;
      e_rd    = (rst_n === 1'b1) && (m_sram.size() != 0)
              && ((m_out.size() + m_fly.size() - (e_pop ? 1 : 0)) < 2);

      checkOutput("in_ready", bus.in_ready, e_ready);
      checkOutput("out_valid", bus.out_valid, e_ov);
      checkOutput("count", bus.count, e_count);
      checkOutput("sram_wr_en", bus.sram_wr_en, e_push);
      checkOutput("sram_rd_en", bus.sram_rd_en, e_rd);
      if (e_ov) checkOutput("out_data", bus.out_data, m_out[0]);
      if (e_push) begin
        checkOutput("sram_wr_addr", bus.sram_wr_addr, m_wptr);
        checkOutput("sram_wr_data", bus.sram_wr_data, bus.in_data);
      end
      if (e_rd) checkOutput("sram_rd_addr", bus.sram_rd_addr, m_rptr);

      if (rst_n !== 1'b1) begin
        m_sram.delete();
        m_fly.delete();
        m_out.delete();
        sb.delete();
        m_wptr = '0;
        m_rptr = '0;
      end else begin
        if (e_pop) begin
          sb_head = sb.pop_front();
          checkOutput("pop_order", bus.out_data, sb_head);
          void'(m_out.pop_front());
        end
        if (m_fly.size() != 0) m_out.push_back(m_fly.pop_front());
        if (e_rd) begin
          m_fly.push_back(m_sram.pop_front());
          m_rptr = m_rptr + 2'd1;
        end
        if (e_push) begin
          m_sram.push_back(bus.in_data);
          sb.push_back(bus.in_data);
          m_wptr = m_wptr + 2'd1;
        end
      end
    end
  end

  // Hard stop if the scenarios ever stall.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int accepted;
    int pops;
    int cyc;
    logic [7:0] popped [8];
    logic [3:0] exp_cnt [4];
    logic       exp_ov  [4];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    model_on = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("reset_in_ready", bus.in_ready, 1'b0);
    checkOutput("reset_out_valid", bus.out_valid, 1'b0);
    checkOutput("reset_count", bus.count, 4'd0);
    checkOutput("reset_rd_en", bus.sram_rd_en, 1'b0);

    // 1: single entry latency, push at cycle 0, visible at cycle 3.
    $display("[TB] scenario 1: single push latency");
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1);
    checkOutput("t1_c0_count", bus.count, 4'd0);
    checkOutput("t1_c0_in_ready", bus.in_ready, 1'b1);
    checkOutput("t1_c0_out_valid", bus.out_valid, 1'b0);
    exp_cnt = '{4'd1, 4'd1, 4'd1, 4'd0};
    exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("t1_c%0d_count", c + 1), bus.count, exp_cnt[c]);
      checkOutput($sformatf("t1_c%0d_out_valid", c + 1), bus.out_valid, exp_ov[c]);
      if (c == 2) checkOutput("t1_c3_out_data", bus.out_data, 8'hA5);
    end

    // 2: fill with the pop side stalled; 4 in SRAM + 2 buffered.
    $display("[TB] scenario 2: fill to capacity");
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h20 + accepted), 1'b0);
      if (bus.in_ready === 1'b1) accepted++;
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t2_accepted", accepted, 6);
    checkOutput("t2_count_full", bus.count, 4'd6);
    checkOutput("t2_in_ready_full", bus.in_ready, 1'b0);
    checkOutput("t2_head", bus.out_data, 8'h20);

    // 3: from full, push and pop every cycle with no bubble on out_valid.
    $display("[TB] scenario 3: sustained streaming from full");
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h40 + accepted), 1'b1);
      checkOutput($sformatf("t3_no_gap_%0d", c), bus.out_valid, 1'b1);
      if (bus.in_ready === 1'b1) accepted++;
    end
    checkOutput("t3_accepted", accepted, 11);
    cyc = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      cyc++;
    end while (bus.count !== 4'd0 && cyc < 40);
    if (cyc >= 40) timeoutFail("t3_drain");

    // 4: random valid/ready with pointer wrap-around.
    $display("[TB] scenario 4: random stream with wrap");
    accepted = 0;
    pops = 0;
    cyc = 0;
    while ((accepted < 20 || bus.count !== 4'd0) && cyc < 400) begin
      applyStimulus(1'b1, (accepted < 20) ? 1'($urandom_range(0, 1)) : 1'b0,
                    8'(8'h80 + accepted), 1'($urandom_range(0, 1)));
      if (bus.in_valid && bus.in_ready === 1'b1) accepted++;
      if (bus.out_ready && bus.out_valid === 1'b1) pops++;
      cyc++;
    end
    if (cyc >= 400) timeoutFail("t4_stream");
    checkOutput("t4_pops", pops, 20);

    // 5: reset while a read is in flight discards it.
    $display("[TB] scenario 5: reset mid-read");
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_rd_issued", bus.sram_rd_en, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_out_valid", bus.out_valid, 1'b0);
    checkOutput("t5_count", bus.count, 4'd0);
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1);
    cyc = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      cyc++;
    end while (bus.out_valid !== 1'b1 && cyc < 10);
    if (cyc >= 10) timeoutFail("t5_wait_valid");
    checkOutput("t5_latency", cyc, 3);
    checkOutput("t5_data", bus.out_data, 8'h3C);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("t5_after_out_valid", bus.out_valid, 1'b0);
    checkOutput("t5_after_count", bus.count, 4'd0);

    // 6: pop every other cycle so the skid register is exercised.
    $display("[TB] scenario 6: toggled out_ready");
    accepted = 0;
    pops = 0;
    cyc = 0;
    while (pops < 8 && cyc < 60) begin
      applyStimulus(1'b1, accepted < 8, 8'(8'h10 + accepted), 1'(cyc % 2));
      if (bus.out_ready && bus.out_valid === 1'b1) begin
        popped[pops] = bus.out_data;
        pops++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) accepted++;
      cyc++;
    end
    if (cyc >= 60) timeoutFail("t6_stream");
    checkOutput("t6_pops", pops, 8);
    for (int i = 0; i < pops; i++) begin
      checkOutput($sformatf("t6_value_%0d", i), popped[i], 8'(8'h10 + i));
    end

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
